// File: rtl/clk_div_prog.sv
// Programmable clock divider with a counter that wraps at an active limit LIM.
// A new limit can come from a preset select (Sp) or from an explicit
// valid/ready request. It is held as pending and only takes effect at a wrap,
// so a half-period is never cut short or stretched mid-count.
// Mode 0 gives a square wave that toggles on each wrap.
// Mode 1 gives a one-cycle pulse that matches Tick.
module clk_div_prog #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BASE  = 12500000,
  parameter int unsigned SEL_W = 2
) (
  input  logic             CLK_in,
  input  logic             RST,
  input  logic             En,
  input  logic             Mode,
  input  logic [SEL_W-1:0] Sp,
  input  logic [WIDTH-1:0] Div_in,
  input  logic             Div_valid,
  output logic             Div_ready,
  output logic             CLK_out,
  output logic             Tick,
  output logic [WIDTH-1:0] Lim_out
);

  // The largest preset, 2^SEL_W * BASE, must fit in WIDTH bits.
  localparam longint unsigned PRESET_MAX = (64'(1) << SEL_W) * 64'(BASE);

  if (WIDTH < 64 && (PRESET_MAX >> WIDTH) != 64'(0)) begin : g_bad_params
    $error("clk_div_prog: largest preset does not fit in WIDTH bits");
  end

  // Maps a select value to its limit: select k gives (k+1)*BASE.
  function automatic logic [WIDTH-1:0] preset_limit(input logic [SEL_W-1:0] sel);
    logic [WIDTH-1:0] mult;
    mult = WIDTH'(sel) + WIDTH'(1);
    return mult * WIDTH'(BASE);
  endfunction

  logic [WIDTH-1:0] cnt_q,  cnt_d;
  logic [WIDTH-1:0] lim_q,  lim_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pv_q,   pv_d;
  logic [SEL_W-1:0] sp_q,   sp_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q,    tick_d;

  logic wrap;
  logic accept;
  logic sp_chg;

  // Counter, wrap detection and divided-output generation
  always_comb begin
    wrap      = En && (cnt_q == lim_q);
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    clk_out_d = clk_out_q;
    if (En) begin
      cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
    end
    tick_d = wrap;
    if (Mode) begin
      clk_out_d = wrap;
    end else begin
      clk_out_d = clk_out_q ^ wrap;
    end
  end

  // Limit update path. A wrap applies only a value that was pending before
  // this cycle. An update captured in the same cycle waits for the next wrap.
  // An explicit request can only be accepted while nothing is pending, so it
  // never collides with an apply. In the same cycle it overrides a preset
  // change.
  always_comb begin
    accept = Div_valid && !pv_q;
    sp_chg = (Sp != sp_q);
    lim_d  = lim_q;
    pend_d = pend_q;
    pv_d   = pv_q;
    sp_d   = sp_q;
    if (wrap && pv_q) begin
      lim_d = pend_q;
      pv_d  = 1'b0;
    end
    if (sp_chg) begin
      sp_d   = Sp;
      pend_d = preset_limit(Sp);
      pv_d   = 1'b1;
    end
    if (accept) begin
      pend_d = Div_in;
      pv_d   = 1'b1;
    end
  end

  // Control state. Reset discards any partial count and any pending limit,
  // and reloads the active limit from the current select.
  always_ff @(posedge CLK_in) begin
    if (RST) begin
      cnt_q     <= '0;
      lim_q     <= preset_limit(Sp);
      pv_q      <= 1'b0;
      sp_q      <= Sp;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      lim_q     <= lim_d;
      pv_q      <= pv_d;
      sp_q      <= sp_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  // The pending value is meaningless while pv_q is low, so it needs no reset
  always_ff @(posedge CLK_in) begin
    pend_q <= pend_d;
  end

  assign Div_ready = !pv_q;
  assign CLK_out   = clk_out_q;
  assign Tick      = tick_q;
  assign Lim_out   = lim_q;

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- WIDTH, 32, counter and limit width.
- BASE, 12500000, preset unit; preset k = (k+1)*BASE.
- SEL_W, 2, width of Sp; there are 2^SEL_W presets.
REQ-002 The block SHALL satisfy the parameter constraint 2^SEL_W*BASE < 2^WIDTH, so presets never truncate.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- CLK_in, in, 1, sole clock; all logic on its rising edge.
- RST, in, 1, synchronous active-high reset.
- En, in, 1, count enable.
- Mode, in, 1, 0 = square wave, 1 = pulse.
- Sp, in, SEL_W, preset select.
- Div_in, in, WIDTH, explicit limit value.
- Div_valid, in, 1, explicit limit request.
- Div_ready, out, 1, explicit limit accepted when high together with Div_valid.
- CLK_out, out, 1, divided output.
- Tick, out, 1, one-cycle pulse on every wrap.
- Lim_out, out, WIDTH, currently active limit.

Function
REQ-005 The block SHALL hold an internal counter CNT, an active limit LIM, a pending limit PEND with flag PV, and the registered select SP_Q.
REQ-006 When En=1 and CNT!=LIM, the block SHALL set CNT<=CNT+1.
REQ-007 When En=1 and CNT==LIM (wrap), the block SHALL set CNT<=0; each half-period therefore lasts LIM+1 cycles.
REQ-008 On a wrap the block SHALL drive Tick=1 for exactly that next cycle; otherwise Tick=0.
REQ-009 With Mode=0, the block SHALL toggle CLK_out on each wrap and hold it otherwise.
REQ-010 With Mode=1, the block SHALL make CLK_out high only on the cycle after a wrap (identical to Tick), and low otherwise.
REQ-011 A Mode change SHALL take effect on the next clock edge; on a 1->0 change, toggling resumes from the current CLK_out value.
REQ-012 When En=0, the block SHALL hold CNT and CLK_out, drive Tick=0, and continue accepting and storing updates.
REQ-013 The block SHALL drive Div_ready = !PV.
REQ-014 On Div_valid && Div_ready, the block SHALL set PEND<=Div_in and PV<=1.
REQ-015 When Sp!=SP_Q, the block SHALL set SP_Q<=Sp, PEND<=(Sp+1)*BASE and PV<=1, overwriting any existing pending value.
REQ-016 When an explicit handshake and an Sp change occur in the same cycle, Div_in SHALL win and SP_Q SHALL still update.
REQ-017 On a wrap with PV=1 (PV already set before this cycle), the block SHALL set LIM<=PEND and PV<=0; the new LIM governs the next half-period.
REQ-018 An update accepted in the same cycle as a wrap SHALL NOT apply at that wrap; it applies at the following wrap.
REQ-019 The block SHALL never change LIM except at a wrap, so no half-period is ever truncated or stretched mid-count.
REQ-020 Div_in=0 SHALL be legal: a wrap occurs every cycle and, in Mode 0, CLK_out toggles every cycle.
REQ-021 The block SHALL drive Lim_out = LIM combinationally from the register.

Reset
REQ-022 While RST=1, the block SHALL set CNT=0, CLK_out=0, Tick=0, PV=0, LIM=(Sp+1)*BASE and SP_Q=Sp, with Div_ready=1 from the first cycle after release.
REQ-023 RST SHALL take priority over En, handshakes and wraps.
REQ-024 An RST asserted mid-period or with PV=1 SHALL discard the pending value and the partial count.

Verification
REQ-025 The bench SHALL use BASE=3 and SEL_W=2, and SHALL cover the following scenarios.
- Sp=0, Mode=0, En=1 after reset -> CLK_out toggles every 4 cycles (period 8); Tick pulses every 4 cycles; Lim_out=3.
- Sp changes 0->2 mid-half-period at CNT=1 -> Lim_out remains 3 until the next wrap, then becomes 9; the next half-period lasts 10 cycles; no short pulse occurs.
- Div_valid=1 with Div_in=0 in the same cycle as a wrap -> Div_ready falls next cycle; the limit applies at the following wrap; Mode=0 CLK_out then toggles every cycle.
- Sp change and Div_valid with Div_in=5 in the same cycle -> Lim_out becomes 5 at the next wrap, not the preset value.
- En=0 for 7 cycles at CNT=2 -> CNT, CLK_out and Tick stay frozen; counting resumes at 3 and the wrap occurs 2 cycles after En rises.
- Mode=1 -> CLK_out equals Tick, high for 1 cycle every LIM+1 cycles; RST asserted with PV=1 -> Lim_out=(Sp+1)*3 and Div_ready=1 after release.
